// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: iterative radix-2 Booth multiplier, one step per clock, start/busy/done handshake
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product_out
);
  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(W1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state, w_next;
  logic [W1-1:0]   r_acc, r_mplr, r_a, w_acc;
  logic            r_q, w_last;
  logic [CW-1:0]   r_cnt;
  logic [2*W1:0]   w_shift;
  logic [2*WIDTH-1:0] r_prod;
  // The extra operand bit lets one signed Booth recurrence cover unsigned operands too
  always_comb begin
    w_acc   = ( r_mplr[0] && !r_q) ? r_acc - r_a :
              (!r_mplr[0] &&  r_q) ? r_acc + r_a : r_acc;
    w_shift = {w_acc[W1-1], w_acc, r_mplr};
    w_last  = r_cnt == CW'(W1 - 1);
    w_next  = r_state;
    w_next  = (r_state == IDLE) ? (start ? RUN : IDLE) :
              (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_a     <= '0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_a    <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
        r_mplr <= {signed_mode & multiplier[WIDTH-1], multiplier};
        r_acc  <= '0;
        r_q    <= 1'b0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        {r_acc, r_mplr, r_q} <= w_shift;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_prod <= w_shift[2*WIDTH:1];
      end
    end
  end
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
  assign product_out = r_prod;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb_booth_multiplier_seq: scoreboard bench for booth_multiplier_seq at WIDTH=32 and WIDTH=8
module tb_booth_multiplier_seq;
  logic        clk = 1'b0;
  logic        clear, start, sm, start8, sm8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic        busy, done, busy8, done8;
  logic [63:0] prod;
  logic [15:0] prod8;
  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clock(clk), .clear(clear), .start(start), .signed_mode(sm),
    .multiplicand(a), .multiplier(b), .busy(busy), .done(done), .product_out(prod));
  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock(clk), .clear(clear), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product_out(prod8));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    sx = s ? {{32{x[31]}}, x} : {32'b0, x};
    sy = s ? {{32{y[31]}}, y} : {32'b0, y};
    return sx * sy;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("spurious_done", {63'b0, done}, 64'd0);
      else check("product", prod, exp_q.pop_front());
    end
    if (done8) begin
      if (exp8_q.size() == 0) check("spurious_done8", {63'b0, done8}, 64'd0);
      else check("product8", {48'b0, prod8}, {48'b0, exp8_q.pop_front()});
    end
  end
  task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y, input logic [63:0] e);
    int k, nb;
    @(negedge clk);
    sm = s; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sm = 1'($urandom);
    k = 1; nb = 0;
    while (!done && k < 100) begin
      nb += int'(busy);
      @(negedge clk);
      k++;
    end
    nb += int'(busy);
    check("latency", 64'(k), 64'd34);
    check("busy_cycles", 64'(nb), 64'd34);
    @(negedge clk);
    check("done_pulse", {63'b0, done}, 64'd0);
    check("busy_after", {63'b0, busy}, 64'd0);
  endtask
  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int k;
    @(negedge clk);
    sm8 = s; a8 = x; b8 = y; start8 = 1'b1;
    exp8_q.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 1;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency8", 64'(k), 64'd10);
    @(negedge clk);
  endtask
  initial begin
    int k, nd;
    logic [31:0] rx, ry;
    logic rs;
    clear = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_prod", prod, 64'd0);
    clear = 1'b0;
    run_op(1'b1, 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run_op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000);
    // abort an operation mid-flight; no result may ever appear for it
    @(negedge clk);
    sm = 1'b1; a = 32'd100; b = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    clear = 1'b1;
    #1;
    check("clr_busy", {63'b0, busy}, 64'd0);
    check("clr_done", {63'b0, done}, 64'd0);
    check("clr_prod", prod, 64'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (45) @(negedge clk);
    run_op(1'b1, 32'd5, 32'd6, 64'd30);
    // start pulses while busy must be ignored
    @(negedge clk);
    sm = 1'b1; a = 32'd12; b = 32'hFFFFFFFE; start = 1'b1;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFE8);
    nd = 0; k = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 33);
      a = $urandom; b = $urandom; sm = 1'($urandom);
      if (done) begin
        nd++;
        k = c;
      end
    end
    start = 1'b0;
    check("ignored_start_dones", 64'(nd), 64'd1);
    check("ignored_start_latency", 64'(k), 64'd34);
    for (int i = 0; i < 8; i++) begin
      rx = $urandom; ry = $urandom; rs = 1'($urandom);
      if (i < 2) rx = 32'd0;
      run_op(rs, rx, ry, model(rs, rx, ry));
    end
    run8(1'b0, 8'h80, 8'h80, 16'h4000);
    run8(1'b1, 8'h80, 8'h80, 16'h4000);
    run8(1'b1, 8'hFF, 8'h01, 16'hFFFF);
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("queue8_empty", 64'(exp8_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
